secure_receiver: RTL and testbench

//  Receive end of the secure routing link. Accepts Hamming(7,4) codewords from the four router output

---
 rtl/secure_receiver_pkg.sv | 19 +
 rtl/secure_receiver_if.sv | 26 ++
 rtl/secure_receiver_decoder.sv | 20 ++
 rtl/secure_receiver.sv | 76 +++++++
 tb/tb_secure_receiver.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/secure_receiver_pkg.sv
// secure_receiver_pkg: Hamming(7,4) field indices, syndrome table and FIFO entry shared by link encoder and receiver
package secure_receiver_pkg;
    localparam int CODE_W = 7;
    localparam int PKT_W = 6;
    localparam int C_A = 0;
    localparam int C_B = 1;
    localparam int C_C = 2;
    localparam int C_P1 = 3;
    localparam int C_D = 4;
    localparam int C_P2 = 5;
    localparam int C_P3 = 6;
    // Indexed by syndrome; entry 0 holds 7, an index no codeword bit has, meaning "no flip"
    localparam logic [2:0] SYN_TO_BIT [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    typedef struct packed {
        logic [1:0] port;
        logic [3:0] data;
        logic       corrected;
    } entry_t;
endpackage

// File: rtl/secure_receiver_if.sv
// secure_receiver_if: four codeword channels in, corrected packet stream and error count out
interface secure_receiver_if
    import secure_receiver_pkg::*;
#(
    parameter int CNT_W = 8
) ();
    logic [3:0]          in_valid;
    logic [3:0]          in_ready;
    logic [0:CODE_W-1]   in_code0;
    logic [0:CODE_W-1]   in_code1;
    logic [0:CODE_W-1]   in_code2;
    logic [0:CODE_W-1]   in_code3;
    logic                out_valid;
    logic                out_ready;
    logic [0:PKT_W-1]    dout;
    logic                out_corrected;
    logic [CNT_W-1:0]    corr_count;
    modport master (
        output in_valid, in_code0, in_code1, in_code2, in_code3, out_ready,
        input  in_ready, out_valid, dout, out_corrected, corr_count
    );
    modport slave (
        input  in_valid, in_code0, in_code1, in_code2, in_code3, out_ready,
        output in_ready, out_valid, dout, out_corrected, corr_count
    );
endinterface

// File: rtl/secure_receiver_decoder.sv
// hamming74_decoder: combinational single-error-correcting Hamming(7,4) decode
module hamming74_decoder
    import secure_receiver_pkg::*;
(
    input  logic [0:CODE_W-1] code,
    output logic [0:3]        data,
    output logic              corrected
);
    logic [2:0]        s;
    logic [0:CODE_W-1] fixed;
    always_comb begin
        s = {code[C_A] ^ code[C_B] ^ code[C_C] ^ code[C_P1],
             code[C_A] ^ code[C_B] ^ code[C_D] ^ code[C_P2],
             code[C_A] ^ code[C_C] ^ code[C_D] ^ code[C_P3]};
        fixed = code;
        for (int i = 0; i < CODE_W; i++) fixed[i] = code[i] ^ (s != 3'd0 && SYN_TO_BIT[s] == 3'(i));
        data = {fixed[C_A], fixed[C_B], fixed[C_C], fixed[C_D]};
        corrected = s != 3'd0;
    end
endmodule

// File: rtl/secure_receiver.sv
// secure_receiver: corrects Hamming(7,4) words from four channels, round-robin into an output FIFO
module secure_receiver
    import secure_receiver_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    secure_receiver_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            mem_d [FIFO_DEPTH];
    entry_t            head;
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [1:0]        rr_q, rr_d, sel;
    logic [CNT_W-1:0]  corr_q, corr_d;
    logic [3:0]        gnt;
    logic [0:CODE_W-1] code;
    logic [0:3]        dec_data;
    logic              dec_corr, full, valid, push, pop;

    hamming74_decoder u_dec (.code(code), .data(dec_data), .corrected(dec_corr));

    always_comb begin
        full = cnt_q == (AW+1)'(FIFO_DEPTH);
        valid = cnt_q != '0;
        gnt = '0;
        sel = rr_q;
        // Scan from the farthest offset down so the nearest valid channel after rr_q wins
        for (int k = 4; k >= 1; k--) begin
            if (bus.in_valid[rr_q + 2'(k)]) begin
                sel = rr_q + 2'(k);
                gnt = 4'b0001 << (rr_q + 2'(k));
            end
        end
        gnt = (rst || full) ? 4'b0000 : gnt;
        push = |gnt;
        pop = valid && bus.out_ready;
        code = sel == 2'd0 ? bus.in_code0 : sel == 2'd1 ? bus.in_code1 : sel == 2'd2 ? bus.in_code2 : bus.in_code3;
        rr_d = push ? sel : rr_q;
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        corr_d = (push && dec_corr && corr_q != '1) ? corr_q + 1'b1 : corr_q;
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = entry_t'({sel, dec_data, dec_corr});
        head = mem_q[rptr_q];
    end

    // Storage is not cleared on reset; an empty count hides stale entries
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            rr_q <= 2'd3;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q <= '0;
            corr_q <= '0;
        end else begin
            rr_q <= rr_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q <= cnt_d;
            corr_q <= corr_d;
        end
    end

    assign bus.in_ready = gnt;
    assign bus.out_valid = valid;
    assign bus.dout = valid ? {head.port, head.data} : '0;
    assign bus.out_corrected = valid && head.corrected;
    assign bus.corr_count = corr_q;
endmodule

// File: tb/tb_secure_receiver.sv
// tb_secure_receiver: directed checks of correction, arbitration, backpressure, saturation and reset
module tb_secure_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_fail = 0;
    always #5 clk = ~clk;

    secure_receiver_if #(.CNT_W(8)) b();
    secure_receiver_if #(.CNT_W(2)) s();
    secure_receiver #(.FIFO_DEPTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(b));
    secure_receiver #(.FIFO_DEPTH(4), .CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(s));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_codes(input logic [0:6] c0, input logic [0:6] c1, input logic [0:6] c2, input logic [0:6] c3);
        b.in_code0 = c0;
        b.in_code1 = c1;
        b.in_code2 = c2;
        b.in_code3 = c3;
    endtask

    task automatic do_reset;
        b.in_valid = 4'b0000;
        s.in_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        b.in_valid = 4'b1111;
        b.out_ready = 1'b1;
        set_codes(7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000);
        tick();
        #1;
        n_cmp++;
        if (b.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got %b want 0000", b.in_ready); end
        n_cmp++;
        if (b.out_valid !== 1'b0 || b.dout !== 6'b000000 || b.out_corrected !== 1'b0)
            begin n_fail++; $display("FAIL reset_out got v=%b d=%b c=%b want 0/000000/0", b.out_valid, b.dout, b.out_corrected); end
        n_cmp++;
        if (b.corr_count !== 8'd0) begin n_fail++; $display("FAIL reset_corr got %0d want 0", b.corr_count); end
        do_reset();
    endtask

    task automatic test_clean;
        do_reset();
        b.out_ready = 1'b1;
        set_codes(7'b0, 7'b0, 7'b1010101, 7'b0);
        b.in_valid = 4'b0100;
        #1;
        n_cmp++;
        if (b.in_ready !== 4'b0100) begin n_fail++; $display("FAIL clean_ready got %b want 0100", b.in_ready); end
        tick();
        b.in_valid = 4'b0000;
        n_cmp++;
        if (b.out_valid !== 1'b1 || b.dout !== 6'b101011 || b.out_corrected !== 1'b0)
            begin n_fail++; $display("FAIL clean_out got v=%b d=%b c=%b want 1/101011/0", b.out_valid, b.dout, b.out_corrected); end
        n_cmp++;
        if (b.corr_count !== 8'd0) begin n_fail++; $display("FAIL clean_corr got %0d want 0", b.corr_count); end
        tick();
        n_cmp++;
        if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_drained got %b want 0", b.out_valid); end
    endtask

    task automatic test_single_error;
        logic [0:6] good, bad, bit_mask;
        do_reset();
        b.out_ready = 1'b1;
        good = 7'b1010101;
        for (int i = 0; i < 7; i++) begin
            bit_mask = 7'b1000000 >> i;
            bad = good ^ bit_mask;
            set_codes(7'b0, 7'b0, bad, 7'b0);
            b.in_valid = 4'b0100;
            tick();
            b.in_valid = 4'b0000;
            n_cmp++;
            if (b.dout !== 6'b101011 || b.out_corrected !== 1'b1)
                begin n_fail++; $display("FAIL flip_c%0d got d=%b c=%b want 101011/1", i, b.dout, b.out_corrected); end
            n_cmp++;
            if (b.corr_count !== 8'(i + 1)) begin n_fail++; $display("FAIL flip_count%0d got %0d want %0d", i, b.corr_count, i + 1); end
        end
        tick();
    endtask

    task automatic test_fairness;
        do_reset();
        b.out_ready = 1'b1;
        set_codes(7'b1010101, 7'b1010101, 7'b1010101, 7'b1010101);
        b.in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (b.in_ready !== 4'b0001 << (k % 4)) begin n_fail++; $display("FAIL fair_grant%0d got %b want %b", k, b.in_ready, 4'b0001 << (k % 4)); end
            tick();
            n_cmp++;
            if (b.out_valid !== 1'b1 || b.dout !== {2'(k % 4), 4'b1011})
                begin n_fail++; $display("FAIL fair_dout%0d got v=%b d=%b want 1/%b", k, b.out_valid, b.dout, {2'(k % 4), 4'b1011}); end
        end
        b.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure;
        logic [5:0] exp [4];
        exp[0] = 6'b000000;
        exp[1] = 6'b011111;
        exp[2] = 6'b101011;
        exp[3] = 6'b110110;
        do_reset();
        b.out_ready = 1'b0;
        set_codes(7'b0000000, 7'b1111111, 7'b1010101, 7'b0110011);
        b.in_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (b.in_ready !== 4'b0001 << k) begin n_fail++; $display("FAIL bp_grant%0d got %b want %b", k, b.in_ready, 4'b0001 << k); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (b.in_ready !== 4'b0000 || b.dout !== exp[0] || b.out_valid !== 1'b1)
                begin n_fail++; $display("FAIL bp_full%0d got r=%b d=%b v=%b want 0000/%b/1", k, b.in_ready, b.dout, b.out_valid, exp[0]); end
            tick();
        end
        b.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (b.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_passthru got %b want 0000", b.in_ready); end
        b.in_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (b.out_valid !== 1'b1 || b.dout !== exp[k])
                begin n_fail++; $display("FAIL bp_drain%0d got v=%b d=%b want 1/%b", k, b.out_valid, b.dout, exp[k]); end
            tick();
        end
        n_cmp++;
        if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", b.out_valid); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp [5];
        exp[0] = 2'd1;
        exp[1] = 2'd2;
        exp[2] = 2'd3;
        exp[3] = 2'd3;
        exp[4] = 2'd3;
        do_reset();
        s.out_ready = 1'b1;
        s.in_code0 = 7'b0000001;
        s.in_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (s.corr_count !== exp[k] || s.out_corrected !== 1'b1)
                begin n_fail++; $display("FAIL sat%0d got n=%0d c=%b want %0d/1", k, s.corr_count, s.out_corrected, exp[k]); end
        end
        s.in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_midstream;
        do_reset();
        b.out_ready = 1'b0;
        set_codes(7'b1110101, 7'b1110101, 7'b1110101, 7'b1110101);
        b.in_valid = 4'b0111;
        repeat (3) tick();
        n_cmp++;
        if (b.corr_count !== 8'd3 || b.out_valid !== 1'b1)
            begin n_fail++; $display("FAIL mid_queued got n=%0d v=%b want 3/1", b.corr_count, b.out_valid); end
        do_reset();
        n_cmp++;
        if (b.out_valid !== 1'b0 || b.corr_count !== 8'd0 || b.dout !== 6'b000000)
            begin n_fail++; $display("FAIL mid_cleared got v=%b n=%0d d=%b want 0/0/000000", b.out_valid, b.corr_count, b.dout); end
        b.in_valid = 4'b1111;
        #1;
        n_cmp++;
        if (b.in_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got %b want 0001", b.in_ready); end
        b.in_valid = 4'b0000;
    endtask

    initial begin
        b.in_valid = 4'b0000;
        b.out_ready = 1'b0;
        s.in_valid = 4'b0000;
        s.out_ready = 1'b1;
        s.in_code0 = 7'b0;
        s.in_code1 = 7'b0;
        s.in_code2 = 7'b0;
        s.in_code3 = 7'b0;
        test_reset();
        test_clean();
        test_single_error();
        test_fairness();
        test_backpressure();
        test_saturation();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
